iddmm_job_loader: RTL and testbench



---
 rtl/iddmm_pkg.sv | 25 ++
 rtl/iddmm_res_buf.sv | 55 +++++
 rtl/iddmm_job_loader.sv | 188 ++++++++++++++++++
 tb/tb_iddmm_job_loader.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/iddmm_pkg.sv
// Shared types and constants for the IDDMM job loader.
package iddmm_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    REQ  = 3'd2,
    RUN  = 3'd3,
    OUT  = 3'd4
  } state_e;

  localparam logic [2:0] WR_X = 3'b001;
  localparam logic [2:0] WR_Y = 3'b010;
  localparam logic [2:0] WR_M = 3'b100;

  // Operand segment that follows the given one in the x, y, m stream order.
  function automatic logic [2:0] next_seg(input logic [2:0] seg);
    case (seg)
      WR_X:    next_seg = WR_Y;
      WR_Y:    next_seg = WR_M;
      default: next_seg = WR_X;
    endcase
  endfunction

endpackage

// File: rtl/iddmm_res_buf.sv
// N-entry result buffer: the engine fills it in order, the output stream drains it in order.
module iddmm_res_buf #(
  parameter int K      = 256,
  parameter int N      = 16,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          wr_en_i,
  input  logic [K-1:0]  wr_data_i,
  output logic          wr_last_o,
  input  logic          rd_en_i,
  output logic [K-1:0]  rd_data_o,
  output logic          rd_last_o,
  output logic          full_o
);

  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(N - 1);

  logic [K-1:0]      mem_q [N];
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic              full_q;

  assign wr_last_o = (wr_ptr_q == PTR_LAST);
  assign rd_last_o = (rd_ptr_q == PTR_LAST);
  assign rd_data_o = mem_q[rd_ptr_q];
  assign full_o    = full_q;

  // Result storage; stale contents are harmless because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (wr_en_i && !full_q) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Pointer and full-flag bookkeeping.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      wr_ptr_q <= {ADDR_W{1'b0}};
      rd_ptr_q <= {ADDR_W{1'b0}};
      full_q   <= 1'b0;
    end else begin
      if (wr_en_i && !full_q) begin
        wr_ptr_q <= wr_last_o ? {ADDR_W{1'b0}} : wr_ptr_q + ADDR_W'(1);
        full_q   <= wr_last_o;
      end
      if (rd_en_i) begin
        rd_ptr_q <= rd_last_o ? {ADDR_W{1'b0}} : rd_ptr_q + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/iddmm_job_loader.sv
// Streams one x/y/m job into the IDDMM engine RAMs, runs the engine and replays its N result words.
module iddmm_job_loader
  import iddmm_pkg::*;
#(
  parameter int K      = 256,
  parameter int N      = 16,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [K-1:0]      in_data,
  input  logic [K-1:0]      cfg_m1,
  output logic [2:0]        wr_ena,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [K-1:0]      wr_data,
  output logic [K-1:0]      wr_m1,
  output logic              task_req,
  input  logic              task_grant,
  input  logic              task_end,
  input  logic [K-1:0]      task_res,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [K-1:0]      out_data,
  output logic              out_last,
  output logic              busy,
  output logic              err_overrun
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(N - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        seg_q, seg_d;
  logic [2:0]        wr_ena_q, wr_ena_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [K-1:0]      wr_data_q, wr_data_d;
  logic [K-1:0]      wr_m1_q, wr_m1_d;
  logic              task_req_q, task_req_d;
  logic              out_valid_q, out_valid_d;
  logic [K-1:0]      out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              err_q, err_d;

  logic              accept_s;
  logic              buf_wr_s, buf_rd_s, buf_clr_s;
  logic              buf_wr_last_s, buf_rd_last_s, buf_full_s;
  logic [K-1:0]      buf_rd_data_s;

  assign in_ready = !rst && ((state_q == IDLE) || (state_q == LOAD));
  assign accept_s = in_valid && in_ready;

  iddmm_res_buf #(.K(K), .N(N), .ADDR_W(ADDR_W)) u_res_buf (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (buf_clr_s),
    .wr_en_i   (buf_wr_s),
    .wr_data_i (task_res),
    .wr_last_o (buf_wr_last_s),
    .rd_en_i   (buf_rd_s),
    .rd_data_o (buf_rd_data_s),
    .rd_last_o (buf_rd_last_s),
    .full_o    (buf_full_s)
  );

  // Next-state, RAM write pipeline and output-stream decode.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    seg_d       = seg_q;
    wr_ena_d    = 3'b000;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_m1_d     = wr_m1_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    buf_wr_s    = 1'b0;
    buf_rd_s    = 1'b0;
    buf_clr_s   = 1'b0;
    // Results arriving when no capture is possible are dropped and flagged.
    err_d = err_q | (task_end && ((state_q == IDLE) || ((state_q == OUT) && buf_full_s)));

    if (accept_s) begin
      wr_ena_d  = seg_q;
      wr_addr_d = addr_q;
      wr_data_d = in_data;
      if (state_q == IDLE) begin
        wr_m1_d = cfg_m1;
      end else begin
        wr_m1_d = wr_m1_q;
      end
      if (addr_q == ADDR_LAST) begin
        addr_d = {ADDR_W{1'b0}};
        seg_d  = next_seg(seg_q);
      end else begin
        addr_d = addr_q + ADDR_W'(1);
      end
    end else begin
      wr_ena_d = 3'b000;
    end

    case (state_q)
      IDLE: begin
        if (accept_s) state_d = LOAD;
        else          state_d = IDLE;
      end
      LOAD: begin
        if (accept_s && (seg_q == WR_M) && (addr_q == ADDR_LAST)) state_d = REQ;
        else                                                     state_d = LOAD;
      end
      REQ: begin
        // A task_end coinciding with the grant is not captured here.
        if (task_req_q && task_grant) state_d = RUN;
        else                          state_d = REQ;
      end
      RUN: begin
        buf_wr_s = task_end;
        if (task_end && buf_wr_last_s) state_d = OUT;
        else                           state_d = RUN;
      end
      OUT: begin
        if (!out_valid_q || (out_ready && !out_last_q)) begin
          buf_rd_s    = 1'b1;
          out_valid_d = 1'b1;
          out_data_d  = buf_rd_data_s;
          out_last_d  = buf_rd_last_s;
        end else if (out_ready) begin
          state_d     = IDLE;
          buf_clr_s   = 1'b1;
          out_valid_d = 1'b0;
          out_data_d  = {K{1'b0}};
          out_last_d  = 1'b0;
        end else begin
          state_d = OUT;
        end
      end
      default: state_d = IDLE;
    endcase

    // Request becomes visible one cycle after REQ entry, i.e. after the final RAM write.
    task_req_d = (state_q == REQ) && (state_d == REQ);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= {ADDR_W{1'b0}};
      seg_q       <= WR_X;
      wr_ena_q    <= 3'b000;
      wr_addr_q   <= {ADDR_W{1'b0}};
      wr_data_q   <= {K{1'b0}};
      wr_m1_q     <= {K{1'b0}};
      task_req_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= {K{1'b0}};
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      seg_q       <= seg_d;
      wr_ena_q    <= wr_ena_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_m1_q     <= wr_m1_d;
      task_req_q  <= task_req_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

  assign wr_ena      = wr_ena_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign wr_m1       = wr_m1_q;
  assign task_req    = task_req_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_last    = out_last_q;
  assign busy        = (state_q != IDLE);
  assign err_overrun = err_q;

endmodule

// File: tb/tb_iddmm_job_loader.sv
// Directed self-checking bench for iddmm_job_loader with K=8, N=4.
module tb_iddmm_job_loader;

  localparam int K = 8;
  localparam int N = 4;
  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [K-1:0]      in_data;
  logic [K-1:0]      cfg_m1;
  logic [2:0]        wr_ena;
  logic [ADDR_W-1:0] wr_addr;
  logic [K-1:0]      wr_data;
  logic [K-1:0]      wr_m1;
  logic              task_req;
  logic              task_grant;
  logic              task_end;
  logic [K-1:0]      task_res;
  logic              out_valid;
  logic              out_ready;
  logic [K-1:0]      out_data;
  logic              out_last;
  logic              busy;
  logic              err_overrun;

  int checks = 0;
  int errors = 0;

  iddmm_job_loader #(.K(K), .N(N), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .cfg_m1      (cfg_m1),
    .wr_ena      (wr_ena),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_m1       (wr_m1),
    .task_req    (task_req),
    .task_grant  (task_grant),
    .task_end    (task_end),
    .task_res    (task_res),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .busy        (busy),
    .err_overrun (err_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_wr_ena", {29'd0, wr_ena}, 32'd0);
    chk("rst_wr_addr", {30'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
    chk("rst_wr_m1", {24'd0, wr_m1}, 32'd0);
    chk("rst_task_req", {31'd0, task_req}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err_overrun}, 32'd0);
  endtask

  // Stream words 01..0C; cfg_m1 changes after the first word to prove it is sampled once.
  task automatic load_job(input bit gap, input logic [K-1:0] m1);
    logic [2:0] exp_ena;
    for (int i = 0; i < 3 * N; i++) begin
      chk("ld_in_ready", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_data  = 8'(i + 1);
      cfg_m1   = (i == 0) ? m1 : 8'hFF;
      @(negedge clk);
      exp_ena = (i < N) ? 3'b001 : ((i < 2 * N) ? 3'b010 : 3'b100);
      chk("wr_ena", {29'd0, wr_ena}, {29'd0, exp_ena});
      chk("wr_addr", {30'd0, wr_addr}, 32'(i % N));
      chk("wr_data", {24'd0, wr_data}, 32'(i + 1));
      chk("wr_m1", {24'd0, wr_m1}, {24'd0, m1});
      chk("ld_busy", {31'd0, busy}, 32'd1);
      in_valid = 1'b0;
      if (gap && i < 3 * N - 1) begin
        @(negedge clk);
        chk("wr_ena_gap", {29'd0, wr_ena}, 32'd0);
      end
    end
    chk("req_in_ready", {31'd0, in_ready}, 32'd0);
    chk("req_early", {31'd0, task_req}, 32'd0);
    @(negedge clk);
    chk("wr_ena_idle", {29'd0, wr_ena}, 32'd0);
  endtask

  task automatic grant_after(input int d);
    for (int j = 0; j <= d; j++) begin
      chk("task_req_hi", {31'd0, task_req}, 32'd1);
      task_grant = (j == d);
      @(negedge clk);
    end
    task_grant = 1'b0;
    chk("task_req_lo", {31'd0, task_req}, 32'd0);
    chk("run_busy", {31'd0, busy}, 32'd1);
  endtask

  // Engine emits cnt result words separated by idle cycles.
  task automatic engine(input logic [K-1:0] base, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      task_end = 1'b1;
      task_res = base + 8'(i);
      @(negedge clk);
      task_end = 1'b0;
      task_res = 8'h00;
      chk("run_out_valid", {31'd0, out_valid}, 32'd0);
      if (i < cnt - 1) @(negedge clk);
    end
  endtask

  task automatic drain(input logic [K-1:0] base, input int stall_idx, input bit inject);
    out_ready = 1'b1;
    if (inject) begin
      task_end = 1'b1;
      task_res = 8'hEE;
    end
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      task_end = 1'b0;
      chk("out_valid", {31'd0, out_valid}, 32'd1);
      chk("out_data", {24'd0, out_data}, {24'd0, base + 8'(k)});
      chk("out_last", {31'd0, out_last}, (k == N - 1) ? 32'd1 : 32'd0);
      chk("out_err", {31'd0, err_overrun}, {31'd0, inject});
      if (k == stall_idx) begin
        out_ready = 1'b0;
        for (int h = 0; h < 3; h++) begin
          @(negedge clk);
          chk("hold_valid", {31'd0, out_valid}, 32'd1);
          chk("hold_data", {24'd0, out_data}, {24'd0, base + 8'(k)});
          chk("hold_last", {31'd0, out_last}, 32'd0);
        end
        out_ready = 1'b1;
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
    chk("end_busy", {31'd0, busy}, 32'd0);
    chk("end_out_valid", {31'd0, out_valid}, 32'd0);
    chk("end_in_ready", {31'd0, in_ready}, 32'd1);
    chk("end_err", {31'd0, err_overrun}, {31'd0, inject});
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    cfg_m1     = 8'h00;
    task_grant = 1'b0;
    task_end   = 1'b0;
    task_res   = 8'h00;
    out_ready  = 1'b0;

    @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // Job 1: continuous load, grant after 5 cycles, no output stall.
    load_job(1'b0, 8'h5A);
    grant_after(5);
    engine(8'hA0, N);
    drain(8'hA0, N, 1'b0);

    // Job 2: gapped load, new cfg_m1, stall on the second result word.
    load_job(1'b1, 8'h77);
    grant_after(2);
    engine(8'hA0, N);
    drain(8'hA0, 1, 1'b0);

    // Job 3: abandoned by reset after two results.
    load_job(1'b0, 8'h33);
    grant_after(0);
    engine(8'hC0, 2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;
    @(negedge clk);

    // Job 4: fresh job; a stray fifth result in OUT sets the sticky error.
    load_job(1'b0, 8'h5A);
    grant_after(1);
    engine(8'hB0, N);
    drain(8'hB0, N, 1'b1);
    repeat (3) @(negedge clk);
    chk("err_sticky", {31'd0, err_overrun}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("err_cleared", {31'd0, err_overrun}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
